// File: rtl/worddemux4_buf_pkg.sv
// Shared datapath definitions for the buffered 1-to-4 word demux: word/channel
// sizes, the MSB-first channel-select type and the 4:1 bit-mux primitive.
package worddemux4_buf_pkg;

   localparam int WORD_W = 16;
   localparam int NCHAN  = 4;

   typedef logic [0:1] ch_sel_t;

   localparam ch_sel_t CH0 = 2'b00;
   localparam ch_sel_t CH1 = 2'b01;
   localparam ch_sel_t CH2 = 2'b10;
   localparam ch_sel_t CH3 = 2'b11;

   function automatic logic mux4(input logic [0:NCHAN-1] d, input ch_sel_t sel);
      logic y;
      y = 1'b0;
      case (sel)
         CH0:     y = d[0];
         CH1:     y = d[1];
         CH2:     y = d[2];
         CH3:     y = d[3];
         default: y = 1'b0;
      endcase
      return y;
   endfunction

endpackage

// File: rtl/worddemux4_buf_if.sv
// Bus between the write-back source and the four demux channels.
// Input word moves when i_valid && o_ready; channel n word moves when o_valid[n] && i_ready[n].
interface worddemux4_buf_if
   import worddemux4_buf_pkg::*;
#(
   parameter int WIDTH = WORD_W
);

   logic               i_valid;
   logic               o_ready;
   ch_sel_t            i_sel;
   logic [0:WIDTH-1]   i_data;
   logic [0:NCHAN-1]   i_en;
   logic [0:NCHAN-1]   o_valid;
   logic [0:NCHAN-1]   i_ready;
   logic [0:WIDTH-1]   o_data0;
   logic [0:WIDTH-1]   o_data1;
   logic [0:WIDTH-1]   o_data2;
   logic [0:WIDTH-1]   o_data3;
   logic               o_drop;

   modport slave (
      input  i_valid, i_sel, i_data, i_en, i_ready,
      output o_ready, o_valid, o_data0, o_data1, o_data2, o_data3, o_drop
   );

   modport master (
      output i_valid, i_sel, i_data, i_en, i_ready,
      input  o_ready, o_valid, o_data0, o_data1, o_data2, o_data3, o_drop
   );

endinterface

// File: rtl/worddemux4_buf_wordslot.sv
// One-entry holding register: a load always wins over a drain, so a same-cycle
// drain+load keeps the slot full with the new word.
module worddemux4_buf_wordslot
   import worddemux4_buf_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             load_i,
   input  logic [0:WIDTH-1] data_i,
   input  logic             drain_i,
   output logic             full_o,
   output logic [0:WIDTH-1] data_o
);

   logic             full_q, full_d;
   logic [0:WIDTH-1] data_q, data_d;

   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (load_i) begin
         full_d = 1'b1;
         data_d = data_i;
      end else if (full_q && drain_i) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign full_o = full_q;
   assign data_o = data_q;

endmodule

// File: rtl/worddemux4_buf.sv
// Buffered 1-to-4 word demultiplexer: select decode, ready mux and drop flag
// around four independent holding slots.
module worddemux4_buf
   import worddemux4_buf_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   worddemux4_buf_if.slave    bus
);

   logic [0:NCHAN-1] full;
   logic [0:NCHAN-1] can_accept;
   logic [0:NCHAN-1] load;
   logic [0:WIDTH-1] slot_data [NCHAN];
   logic             accept;
   logic             sel_en;
   logic             drop_q, drop_d;

   // Only the selected channel can stall the input; a disabled channel always accepts.
   always_comb begin
      can_accept = '0;
      for (int n = 0; n < NCHAN; n++) begin
         can_accept[n] = !bus.i_en[n] || !full[n] || bus.i_ready[n];
      end
   end

   assign bus.o_ready = mux4(can_accept, bus.i_sel);
   assign accept      = bus.i_valid && bus.o_ready;
   assign sel_en      = mux4(bus.i_en, bus.i_sel);

   always_comb begin
      load = '0;
      for (int n = 0; n < NCHAN; n++) begin
         load[n] = accept && (bus.i_sel == 2'(n)) && bus.i_en[n];
      end
   end

   assign drop_d = accept && !sel_en;

   for (genvar g = 0; g < NCHAN; g++) begin : g_slot
      worddemux4_buf_wordslot #(.WIDTH(WIDTH)) u_slot (
         .clk_i   (i_clk),
         .rst_n_i (i_rst_n),
         .load_i  (load[g]),
         .data_i  (bus.i_data),
         .drain_i (bus.i_ready[g]),
         .full_o  (full[g]),
         .data_o  (slot_data[g])
      );
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         drop_q <= 1'b0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign bus.o_valid = full;
   assign bus.o_data0 = slot_data[0];
   assign bus.o_data1 = slot_data[1];
   assign bus.o_data2 = slot_data[2];
   assign bus.o_data3 = slot_data[3];
   assign bus.o_drop  = drop_q;

endmodule

// File: tb/tb_worddemux4_buf.sv
// Directed bench for worddemux4_buf: per-cycle vector table with full output
// expectations, a channel-3 drain scoreboard, and hand-written reset sequences.
module tb_worddemux4_buf;

   localparam int W = 16;
   localparam int NROWS = 20;

   logic clk;
   logic rst_n;

   worddemux4_buf_if #(.WIDTH(W)) bus ();

   worddemux4_buf #(.WIDTH(W)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- vectors ----------------
   typedef struct {
      logic         v;
      logic [0:1]   sel;
      logic [W-1:0] data;
      logic [0:3]   en;
      logic [0:3]   rdy;
      logic         er;
      logic [0:3]   ev;
      logic [W-1:0] d0;
      logic [W-1:0] d1;
      logic [W-1:0] d2;
      logic [W-1:0] d3;
      logic         drop;
   } vec_t;

   vec_t tbl [NROWS];

   int checks   = 0;
   int failures = 0;
   int drains3  = 0;
   logic [W-1:0] exp_q [$];
   logic [W-1:0] front;
   logic         prev_v3;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [0:1] sel, input logic [W-1:0] data,
                        input logic [0:3] en, input logic [0:3] rdy);
      bus.i_valid = v;
      bus.i_sel   = sel;
      bus.i_data  = data;
      bus.i_en    = en;
      bus.i_ready = rdy;
   endtask

   task automatic check_outs(input string tag, input logic [0:3] ev, input logic [W-1:0] d0,
                             input logic [W-1:0] d1, input logic [W-1:0] d2,
                             input logic [W-1:0] d3, input logic drop);
      check({tag, " o_valid"}, 32'(bus.o_valid), 32'(ev));
      check({tag, " o_data0"}, 32'(bus.o_data0), 32'(d0));
      check({tag, " o_data1"}, 32'(bus.o_data1), 32'(d1));
      check({tag, " o_data2"}, 32'(bus.o_data2), 32'(d2));
      check({tag, " o_data3"}, 32'(bus.o_data3), 32'(d3));
      check({tag, " o_drop"},  32'(bus.o_drop),  32'(drop));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //            v  sel    data      en       rdy      er   ev       d0        d1        d2        d3        drop
      // streaming
      tbl[0]  = '{1'b1, 2'b00, 16'h1234, 4'b1111, 4'b1111, 1'b1, 4'b1000, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0};
      tbl[1]  = '{1'b1, 2'b11, 16'hABCD, 4'b1111, 4'b1111, 1'b1, 4'b0001, 16'h1234, 16'h0000, 16'h0000, 16'hABCD, 1'b0};
      tbl[2]  = '{1'b1, 2'b10, 16'h00FF, 4'b1111, 4'b1111, 1'b1, 4'b0010, 16'h1234, 16'h0000, 16'h00FF, 16'hABCD, 1'b0};
      tbl[3]  = '{1'b0, 2'b00, 16'h0000, 4'b1111, 4'b1111, 1'b1, 4'b0000, 16'h1234, 16'h0000, 16'h00FF, 16'hABCD, 1'b0};
      // stall isolation: ch2 consumer stalled
      tbl[4]  = '{1'b1, 2'b10, 16'h5555, 4'b1111, 4'b1101, 1'b1, 4'b0010, 16'h1234, 16'h0000, 16'h5555, 16'hABCD, 1'b0};
      tbl[5]  = '{1'b1, 2'b10, 16'h7777, 4'b1111, 4'b1101, 1'b0, 4'b0010, 16'h1234, 16'h0000, 16'h5555, 16'hABCD, 1'b0};
      tbl[6]  = '{1'b1, 2'b01, 16'h8888, 4'b1111, 4'b1101, 1'b1, 4'b0110, 16'h1234, 16'h8888, 16'h5555, 16'hABCD, 1'b0};
      tbl[7]  = '{1'b0, 2'b00, 16'h0000, 4'b1111, 4'b1111, 1'b1, 4'b0000, 16'h1234, 16'h8888, 16'h5555, 16'hABCD, 1'b0};
      // back-to-back on ch0
      tbl[8]  = '{1'b1, 2'b00, 16'h0001, 4'b1111, 4'b1111, 1'b1, 4'b1000, 16'h0001, 16'h8888, 16'h5555, 16'hABCD, 1'b0};
      tbl[9]  = '{1'b1, 2'b00, 16'h0002, 4'b1111, 4'b1111, 1'b1, 4'b1000, 16'h0002, 16'h8888, 16'h5555, 16'hABCD, 1'b0};
      tbl[10] = '{1'b1, 2'b00, 16'h0003, 4'b1111, 4'b1111, 1'b1, 4'b1000, 16'h0003, 16'h8888, 16'h5555, 16'hABCD, 1'b0};
      tbl[11] = '{1'b0, 2'b00, 16'h0000, 4'b1111, 4'b1111, 1'b1, 4'b0000, 16'h0003, 16'h8888, 16'h5555, 16'hABCD, 1'b0};
      // disabled ch1
      tbl[12] = '{1'b1, 2'b01, 16'hDEAD, 4'b1011, 4'b1111, 1'b1, 4'b0000, 16'h0003, 16'h8888, 16'h5555, 16'hABCD, 1'b1};
      tbl[13] = '{1'b0, 2'b01, 16'h0000, 4'b1011, 4'b1111, 1'b1, 4'b0000, 16'h0003, 16'h8888, 16'h5555, 16'hABCD, 1'b0};
      // same-cycle drain and reload on ch3
      tbl[14] = '{1'b1, 2'b11, 16'h1111, 4'b1111, 4'b1110, 1'b1, 4'b0001, 16'h0003, 16'h8888, 16'h5555, 16'h1111, 1'b0};
      tbl[15] = '{1'b1, 2'b11, 16'h2222, 4'b1111, 4'b1111, 1'b1, 4'b0001, 16'h0003, 16'h8888, 16'h5555, 16'h2222, 1'b0};
      tbl[16] = '{1'b0, 2'b11, 16'h0000, 4'b1111, 4'b1111, 1'b1, 4'b0000, 16'h0003, 16'h8888, 16'h5555, 16'h2222, 1'b0};
      // disabling a full channel does not flush it
      tbl[17] = '{1'b1, 2'b11, 16'h3333, 4'b1111, 4'b1110, 1'b1, 4'b0001, 16'h0003, 16'h8888, 16'h5555, 16'h3333, 1'b0};
      tbl[18] = '{1'b0, 2'b11, 16'h0000, 4'b1110, 4'b1110, 1'b1, 4'b0001, 16'h0003, 16'h8888, 16'h5555, 16'h3333, 1'b0};
      tbl[19] = '{1'b0, 2'b11, 16'h0000, 4'b1110, 4'b1111, 1'b1, 4'b0000, 16'h0003, 16'h8888, 16'h5555, 16'h3333, 1'b0};

      // initial reset
      rst_n = 1'b0;
      drive(1'b0, 2'b00, 16'h0000, 4'b1111, 4'b1111);
      tick();
      tick();
      check("reset o_ready", 32'(bus.o_ready), 32'd1);
      check_outs("reset", 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
      rst_n = 1'b1;
      tick();

      // table
      prev_v3 = 1'b0;
      for (int i = 0; i < NROWS; i++) begin
         drive(tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].en, tbl[i].rdy);
         #1;
         check($sformatf("row%0d o_ready", i), 32'(bus.o_ready), 32'(tbl[i].er));
         if (prev_v3 && tbl[i].rdy[3]) begin
            if (exp_q.size() == 0) begin
               check($sformatf("row%0d ch3 drain with empty queue", i), 32'd1, 32'd0);
            end else begin
               front = exp_q.pop_front();
               drains3++;
               check($sformatf("row%0d ch3 drained word", i), 32'(bus.o_data3), 32'(front));
            end
         end
         tick();
         check_outs($sformatf("row%0d", i), tbl[i].ev, tbl[i].d0, tbl[i].d1,
                    tbl[i].d2, tbl[i].d3, tbl[i].drop);
         if (tbl[i].v && tbl[i].er && tbl[i].en[3] && tbl[i].sel == 2'b11)
            exp_q.push_back(tbl[i].data);
         prev_v3 = tbl[i].ev[3];
      end
      check("ch3 words left undrained", 32'(exp_q.size()), 32'd0);
      check("ch3 drain count", 32'(drains3), 32'd4);

      // reset mid-stream: ch1 full and a drop pending
      drive(1'b1, 2'b01, 16'h4444, 4'b1111, 4'b1011);
      #1;
      check("mid ch1 load o_ready", 32'(bus.o_ready), 32'd1);
      tick();
      check_outs("mid load", 4'b0100, 16'h0003, 16'h4444, 16'h5555, 16'h3333, 1'b0);
      drive(1'b1, 2'b01, 16'hBEEF, 4'b1011, 4'b1011);
      #1;
      check("mid drop o_ready", 32'(bus.o_ready), 32'd1);
      tick();
      check_outs("mid drop", 4'b0100, 16'h0003, 16'h4444, 16'h5555, 16'h3333, 1'b1);
      drive(1'b0, 2'b00, 16'h0000, 4'b1111, 4'b1011);
      #1;
      rst_n = 1'b0;
      #1;
      check_outs("async reset", 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
      tick();
      check("in reset o_ready", 32'(bus.o_ready), 32'd1);
      rst_n = 1'b1;
      tick();
      check_outs("after reset", 4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);

      // first word after reset
      drive(1'b1, 2'b00, 16'h9999, 4'b1111, 4'b1111);
      #1;
      check("post reset o_ready", 32'(bus.o_ready), 32'd1);
      tick();
      check_outs("post reset", 4'b1000, 16'h9999, 16'h0, 16'h0, 16'h0, 1'b0);
      drive(1'b0, 2'b00, 16'h0000, 4'b1111, 4'b1111);
      tick();
      check_outs("post reset drain", 4'b0000, 16'h9999, 16'h0, 16'h0, 16'h0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/worddemux4_buf.md
# worddemux4_buf

Buffered 1-to-4 word demultiplexer for the 16-bit CPU datapath. It routes one input word stream to one of four destination channels, chosen by a 2-bit select. Each channel has a one-entry holding register with a valid/ready handshake. It is the write-side counterpart of the word select muxes: it sits between the write-back source and up to four consumers (register-bank ports, output latch, bus interface) and decouples their stalls from one another.

## Interface
Parameters:
- WIDTH, 16, data word width; all data ports are [0:WIDTH-1], bit 0 is MSB.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  input word present.
- o_ready  out  1  block can accept the input word this cycle.
- i_sel  in  [0:1]  destination channel; i_sel[0] is MSB (00→ch0, 01→ch1, 10→ch2, 11→ch3).
- i_data  in  [0:WIDTH-1]  input word.
- i_en  in  [0:3]  per-channel enable; bit n enables channel n.
- o_valid  out  [0:3]  channel n holds a word.
- i_ready  in  [0:3]  consumer n takes the word this cycle.
- o_data0..o_data3  out  [0:WIDTH-1]  channel holding-register contents.
- o_drop  out  1  one-cycle pulse: the word accepted last cycle was discarded (channel disabled).

## Operation
- Accept: the input handshake completes when i_valid && o_ready.
- Ready rule: o_ready = !i_en[i_sel] || !full[i_sel] || i_ready[i_sel].
  - It depends only on the selected channel; the other channels never stall the input.
  - o_ready is combinational from i_sel, i_en and i_ready.
- Enabled channel, on accept: the word loads into slot[i_sel] and full[i_sel] sets.
- Disabled channel, on accept: the word is always accepted and discarded. No slot changes. o_drop is 1 in the following cycle.
- Drain: channel n empties when o_valid[n] && i_ready[n], unless it is reloaded in the same cycle.
- Same-cycle drain and load on one channel: the old word leaves, the new word loads, and full stays 1. Full throughput is one word per cycle per channel.
- Drain on one channel and load on another in the same cycle: the two are independent.
- o_valid[n] = full[n]. o_data n is the slot register output and is stable while o_valid[n] && !i_ready[n].
- Ordering: words to the same channel leave in acceptance order. No ordering guarantee across channels.
- Changing i_en[n] while channel n is full does not flush it; the held word still drains normally.
- i_ready[n] while !o_valid[n] has no effect.
- X on i_data/i_sel is ignored when i_valid=0.

## Timing
- Reset (asynchronous assert, synchronous to i_clk on release) forces:
  - o_valid=0000, all o_data=0, o_drop=0, all internal full flags 0.
  - With i_en≠0000 after reset, o_ready=1.
- Reset mid-operation discards held words immediately and emits no o_drop.
- Latency: a word accepted at edge k appears on o_data/o_valid after edge k, i.e. one cycle.
- o_drop is registered: it asserts in the cycle after the discarding accept.
- No combinational path from i_data to any output.

## Structure
- Shared CPU package holds:
  - WORD_W=16;
  - NCHAN=4;
  - the channel-select type (2-bit, MSB-first);
  - channel encoding constants CH0..CH3.
- Sub-module wordslot: one-entry holding register with load, drain, full flag and data register. Instantiate it four times, with load = accept && (i_sel==n) && i_en[n].
- Top level holds the select decode, the ready mux (reuses the mux4 primitive on the per-channel can-accept bits) and the o_drop register.

## Test plan
- Reset: i_rst_n low mid-stream with ch1 full → o_valid=0000, o_data1=0, o_drop=0 asynchronously.
- Streaming: i_en=1111, i_ready=1111, send 0x1234 sel=00, 0xABCD sel=11, 0x00FF sel=10 on consecutive cycles → o_ready stays 1; each word appears one cycle later on o_data0/o_data3/o_data2 with one-cycle o_valid.
- Stall isolation: i_ready[2]=0, ch2 holds 0x5555. Send 0x7777 sel=10 → o_ready=0 and o_data2 holds 0x5555. Send 0x8888 sel=01 → accepted, o_data1=0x8888 next cycle.
- Full-throughput same channel: i_ready[0]=1, send 0x0001, 0x0002, 0x0003 to sel=00 back-to-back → o_valid[0] held 1, o_data0 shows 1, 2, 3 on successive cycles, o_ready never drops.
- Disabled channel: i_en=1011, send 0xDEAD sel=01 → accepted (o_ready=1), o_drop=1 for exactly one cycle, o_valid[1] stays 0.
- Simultaneous events: ch3 full with 0x1111, i_ready[3]=1 and new 0x2222 sel=11 in the same cycle → o_valid[3] stays 1 and o_data3=0x2222 next cycle; 0x1111 counted as drained once.
